// File: rtl/pkt_chk_pkg.sv
// pkt_chk_pkg: shared types and LFSR constants for the packet order checker. rev 1.0
`default_nettype none
package pkt_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  typedef struct packed {
    logic nosop;
    logic sop;
    logic ovf;
  } err_flags_t;

  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_chk_lfsr.sv
// pkt_chk_lfsr: free-running 16-bit LFSR for random sink backpressure. rev 1.0
// Only compiled when PKT_CHK_BACKPRESSURE_EN is defined.
`default_nettype none
`ifdef PKT_CHK_BACKPRESSURE_EN
module pkt_chk_lfsr
  import pkt_chk_pkg::*;
(
  input  logic        clk_i,
  input  logic        arstn_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_next(lfsr_q);
  end

  assign lfsr_o = lfsr_q;

endmodule
`endif
`default_nettype wire

// File: rtl/pkt_order_checker.sv
// pkt_order_checker: Avalon-ST sink checking framing, non-decreasing payload and length per packet. rev 1.0
// Optional random backpressure under PKT_CHK_BACKPRESSURE_EN.
`default_nettype none
module pkt_order_checker
  import pkt_chk_pkg::*;
#(
  parameter  int DWIDTH      = 8,
  parameter  int MAX_PKT_LEN = 1024,
  parameter  int CNT_W       = 16,
  localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              sorted_o,
  output logic              err_nosop_o,
  output logic              err_sop_o,
  output logic              err_ovf_o,
  output logic [CNT_W-1:0]  pkt_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT_LEN);

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] prev_q, prev_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              order_q, order_d;
  err_flags_t        flags_q, flags_d;
  logic              ready_q;
  logic [LEN_W-1:0]  rlen_q, rlen_d;
  logic              rsorted_q, rsorted_d;
  err_flags_t        rerr_q, rerr_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              accept;

`ifdef PKT_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr;

  pkt_chk_lfsr u_lfsr (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .lfsr_o  (lfsr)
  );

  assign snk_ready_o = ready_q & lfsr[0];
`else
  assign snk_ready_o = ready_q;
`endif

  assign accept = snk_valid_i && snk_ready_o;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    len_d     = len_q;
    order_d   = order_q;
    flags_d   = flags_q;
    rlen_d    = rlen_q;
    rsorted_d = rsorted_q;
    rerr_d    = rerr_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (snk_startofpacket_i) begin
            prev_d      = snk_data_i;
            len_d       = LEN_W'(1);
            order_d     = 1'b0;
            flags_d.sop = 1'b0;
            flags_d.ovf = 1'b0;
            state_d     = snk_endofpacket_i ? ST_REPORT : ST_RECV;
          end else begin
            flags_d.nosop = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (accept) begin
          if (len_q == LEN_MAX) flags_d.ovf = 1'b1;
          if (snk_startofpacket_i) begin
            flags_d.sop = 1'b1;
            len_d       = LEN_W'(1);
            order_d     = 1'b0;
          end else begin
            if (snk_data_i < prev_q) order_d = 1'b1;
            if (len_q != LEN_MAX)    len_d   = len_q + LEN_W'(1);
          end
          prev_d = snk_data_i;
          if (snk_endofpacket_i) state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        flags_d.nosop = 1'b0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Results are latched on entry to REPORT so they include the EOP beat.
    if (state_q != ST_REPORT && state_d == ST_REPORT) begin
      rlen_d    = len_d;
      rsorted_d = !order_d;
      rerr_d    = flags_d;
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      if (|flags_d) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      len_q     <= '0;
      order_q   <= 1'b0;
      flags_q   <= '0;
      ready_q   <= 1'b0;
      rlen_q    <= '0;
      rsorted_q <= 1'b0;
      rerr_q    <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      len_q     <= len_d;
      order_q   <= order_d;
      flags_q   <= flags_d;
      ready_q   <= (state_d != ST_REPORT);
      rlen_q    <= rlen_d;
      rsorted_q <= rsorted_d;
      rerr_q    <= rerr_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign done_o      = (state_q == ST_REPORT);
  assign len_o       = rlen_q;
  assign sorted_o    = rsorted_q;
  assign err_nosop_o = rerr_q.nosop;
  assign err_sop_o   = rerr_q.sop;
  assign err_ovf_o   = rerr_q.ovf;
  assign pkt_cnt_o   = pkt_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_order_checker.sv
// tb_pkt_order_checker: directed table, corner sequences and randomized packets against a queue-based model.
`default_nettype none
module tb_pkt_order_checker;

  localparam int DW   = 8;
  localparam int MAXL = 1024;
  localparam int CW   = 16;
  localparam int LW   = $clog2(MAXL + 1);

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic [DW-1:0] data = '0;
  logic          sop = 1'b0, eop = 1'b0, valid = 1'b0;
  logic          ready, done, sorted, e_nosop_o, e_sop_o, e_ovf_o;
  logic [LW-1:0] len;
  logic [CW-1:0] pkt_cnt, err_cnt;

  always #5 clk = ~clk;

  pkt_order_checker #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL), .CNT_W(CW)) dut (
    .clk_i               (clk),
    .arstn_i             (arstn),
    .snk_data_i          (data),
    .snk_startofpacket_i (sop),
    .snk_endofpacket_i   (eop),
    .snk_valid_i         (valid),
    .snk_ready_o         (ready),
    .done_o              (done),
    .len_o               (len),
    .sorted_o            (sorted),
    .err_nosop_o         (e_nosop_o),
    .err_sop_o           (e_sop_o),
    .err_ovf_o           (e_ovf_o),
    .pkt_cnt_o           (pkt_cnt),
    .err_cnt_o           (err_cnt)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the current packet is kept as a list of beats and judged at EOP.
  int pkt_q[$];
  bit in_pkt, nosop_p, sop_e, ovf_e;
  int m_len, m_pkt, m_err;
  bit m_sorted, m_nosop, m_sop, m_ovf;

  task automatic model_reset();
    pkt_q.delete();
    in_pkt = 0; nosop_p = 0; sop_e = 0; ovf_e = 0;
    m_len = 0; m_pkt = 0; m_err = 0;
    m_sorted = 0; m_nosop = 0; m_sop = 0; m_ovf = 0;
  endtask

  task automatic model_beat(input int d, input bit s, input bit e, output bit rep);
    rep = 0;
    if (!in_pkt) begin
      if (!s) begin
        nosop_p = 1;
        return;
      end
      in_pkt = 1; sop_e = 0; ovf_e = 0;
      pkt_q.delete();
    end else begin
      if (pkt_q.size() >= MAXL) ovf_e = 1;
      if (s) begin
        sop_e = 1;
        pkt_q.delete();
      end
    end
    pkt_q.push_back(d);
    if (e) begin
      m_len    = (pkt_q.size() > MAXL) ? MAXL : pkt_q.size();
      m_sorted = 1;
      for (int i = 1; i < pkt_q.size(); i++)
        if (pkt_q[i] < pkt_q[i-1]) m_sorted = 0;
      m_nosop = nosop_p; m_sop = sop_e; m_ovf = ovf_e;
      m_pkt   = (m_pkt + 1) % (1 << CW);
      if (nosop_p || sop_e || ovf_e) m_err = (m_err + 1) % (1 << CW);
      nosop_p = 0;
      in_pkt  = 0;
      rep     = 1;
    end
  endtask

  // One clock: decide acceptance from the held inputs, advance, then check 1 ns after the edge.
  task automatic tick(output bit acc);
    bit rep;
    rep = 0;
    acc = valid && ready;
    if (acc) model_beat(int'(data), sop, eop, rep);
    @(posedge clk); #1;
    chk("done", done, rep);
    chk("ready", ready, !rep);
    if (rep) begin
      chk("rep_len", len, m_len);
      chk("rep_sorted", sorted, m_sorted);
      chk("rep_nosop", e_nosop_o, m_nosop);
      chk("rep_sop", e_sop_o, m_sop);
      chk("rep_ovf", e_ovf_o, m_ovf);
      chk("rep_pkt_cnt", pkt_cnt, m_pkt);
      chk("rep_err_cnt", err_cnt, m_err);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit s, input bit e);
    bit acc;
    acc = 0;
    data = d; sop = s; eop = e; valid = 1'b1;
    for (int n = 0; n < 16 && !acc; n++) tick(acc);
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: beat %0h not accepted within 16 cycles", d);
    end
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  task automatic idle();
    bit acc;
    valid = 1'b0;
    tick(acc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_len"}, len, 0);
    chk({tag, "_sorted"}, sorted, 0);
    chk({tag, "_errs"}, {e_nosop_o, e_sop_o, e_ovf_o}, 0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    bit s, e, chk_en;
    int len;
    bit srt, nosop, sp, ovf;
    int pkt, err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d, plen, step;
    bit mono, s;

    tbl = '{
      '{8'd1,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{8'd3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{8'd3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{8'd9,   0, 1, 1, 4, 1, 0, 0, 0, 1, 0},
      '{8'd5,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{8'd2,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{8'd7,   0, 1, 1, 3, 0, 0, 0, 0, 2, 0},
      '{8'hFF,  1, 1, 1, 1, 1, 0, 0, 0, 3, 0},
      '{8'h11,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{8'd1,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{8'd2,   0, 1, 1, 2, 1, 1, 0, 0, 4, 1},
      '{8'd1,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{8'd2,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{8'd0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{8'd4,   0, 1, 1, 2, 1, 0, 1, 0, 5, 2}
    };

    model_reset();
    #23;
    chk_all_zero("reset");
    arstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].d, tbl[i].s, tbl[i].e);
      if (tbl[i].chk_en) begin
        chk("tbl_done", done, 1);
        chk("tbl_ready", ready, 0);
        chk("tbl_len", len, tbl[i].len);
        chk("tbl_sorted", sorted, tbl[i].srt);
        chk("tbl_nosop", e_nosop_o, tbl[i].nosop);
        chk("tbl_sop", e_sop_o, tbl[i].sp);
        chk("tbl_ovf", e_ovf_o, tbl[i].ovf);
        chk("tbl_pkt_cnt", pkt_cnt, tbl[i].pkt);
        chk("tbl_err_cnt", err_cnt, tbl[i].err);
      end
    end

    // Overlong packet: MAX_PKT_LEN+2 beats.
    send(8'd7, 1, 0);
    for (int i = 0; i < MAXL; i++) send(8'd7, 0, 0);
    send(8'd7, 0, 1);
    chk("ovf_flag", e_ovf_o, 1);
    chk("ovf_len", len, MAXL);
    chk("ovf_pkt_cnt", pkt_cnt, 6);
    chk("ovf_err_cnt", err_cnt, 3);
    idle();

    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 7) == 0) send(DW'($urandom_range(0, 255)), 0, 0);
      repeat ($urandom_range(0, 2)) idle();
      plen = $urandom_range(1, 8);
      mono = 1'($urandom_range(0, 1));
      d    = $urandom_range(0, 64);
      for (int k = 0; k < plen; k++) begin
        s = (k == 0) || ($urandom_range(0, 15) == 0);
        if (mono) begin
          step = $urandom_range(0, 3);
          d    = (d + step > 255) ? 255 : d + step;
        end else begin
          d = $urandom_range(0, 255);
        end
        send(d[7:0], s, k == plen - 1);
        if ($urandom_range(0, 3) == 0) idle();
      end
    end

    // Asynchronous reset mid-packet, between clock edges.
    send(8'd3, 1, 0);
    send(8'd4, 0, 0);
    #2 arstn = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    #2 arstn = 1'b1;
    send(8'd10, 1, 0);
    send(8'd20, 0, 1);
    chk("post_rst_pkt_cnt", pkt_cnt, 1);
    chk("post_rst_len", len, 2);
    chk("post_rst_sorted", sorted, 1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
